input_route_unit: RTL and testbench

Per-input-port stage directly downstream of the router's 8x32 input flit FIFO. It pops flits from the FIFO and computes the XY route from each head flit, then applies that route to every flit of the packet. Flits are presented to the switch allocator with a valid/ready handshake. A two-entry output store (output register plus skid register) sustains one flit per cycle despite the FIFO's one-cycle read latency.

---
 rtl/input_route_unit_if.sv | 29 ++
 rtl/input_route_unit.sv | 151 +++++++++++++++
 tb/tb_input_route_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_route_unit_if.sv
// Bundles the FIFO read port and the switch-allocator output port of one
// router input. The route unit is the master; the FIFO and allocator side is the slave.
interface input_route_unit_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: a flit moves on every rising clk edge where out_valid && out_ready.
  // out_valid never waits on out_ready, and out_* stay frozen while out_valid && !out_ready.
  // A pop (fifo_rd_en) returns its flit on fifo_rd_data one cycle later.
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [4:0]            out_port;
  logic                  out_head;
  logic                  out_tail;
  logic                  err_flit;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_port, out_head, out_tail, err_flit
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_port, out_head, out_tail, err_flit
  );
endinterface

// File: rtl/input_route_unit.sv
// Router input stage: pops flits from the input FIFO, XY-routes each packet from
// its head flit, and presents flits to the switch allocator through a two-entry store.
module input_route_unit #(
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input_route_unit_if.master    bus,
  output logic                  dbg_state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [4:0]            port;
    logic                  head;
    logic                  tail;
  } entry_t;

  localparam logic [4:0] PORT_L = 5'b00001;
  localparam logic [4:0] PORT_N = 5'b00010;
  localparam logic [4:0] PORT_E = 5'b00100;
  localparam logic [4:0] PORT_S = 5'b01000;
  localparam logic [4:0] PORT_W = 5'b10000;
  localparam logic [1:0] CX     = CUR_X[1:0];
  localparam logic       CY     = CUR_Y[0];

  state_e     state_q, state_d;
  logic [4:0] route_q, route_d;
  entry_t     out_q, out_d, skid_q, skid_d;
  logic       out_vld_q, out_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic       rd_pend_q, rd_pend_d;

  logic [1:0] ftype;
  logic [1:0] dst_x;
  logic       dst_y;
  logic [4:0] calc_port;
  entry_t     arr_e;
  logic       drop, err, arrive, fire, rd_en;
  logic [2:0] occ;

  // Type bit 0 marks a head (head/single), bit 1 marks a tail (tail/single).
  always_comb begin
    ftype = bus.fifo_rd_data[DATA_WIDTH-1 -: 2];
    dst_x = bus.fifo_rd_data[DATA_WIDTH-3 -: 2];
    dst_y = bus.fifo_rd_data[DATA_WIDTH-5];
    if (dst_x > CX)      calc_port = PORT_E;
    else if (dst_x < CX) calc_port = PORT_W;
    else if (dst_y > CY) calc_port = PORT_S;
    else if (dst_y < CY) calc_port = PORT_N;
    else                 calc_port = PORT_L;
  end

  // Packet FSM, evaluated only in the cycle a popped flit lands on fifo_rd_data.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    drop    = 1'b0;
    err     = 1'b0;
    arr_e   = '{data: bus.fifo_rd_data, port: route_q, head: ftype[0], tail: ftype[1]};
    if (rd_pend_q) begin
      if (state_q == ST_IDLE) begin
        if (ftype[0]) begin
          arr_e.port = calc_port;
          if (!ftype[1]) begin
            route_d = calc_port;
            state_d = ST_PKT;
          end
        end else begin
          drop = 1'b1;
          err  = 1'b1;
        end
      end else begin
        if (ftype[0]) begin
          err        = 1'b1;
          arr_e.port = calc_port;
          if (ftype[1]) begin
            state_d = ST_IDLE;
          end else begin
            route_d = calc_port;
          end
        end else if (ftype[1]) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Occupancy counts the in-flight pop so a landing slot is always reserved.
  always_comb begin
    arrive     = rd_pend_q & ~drop;
    fire       = out_vld_q & bus.out_ready;
    occ        = {2'b00, out_vld_q} + {2'b00, skid_vld_q} + {2'b00, rd_pend_q} - {2'b00, fire};
    rd_en      = rst_n & ~bus.fifo_empty & (occ < 3'd2);
    rd_pend_d  = rd_en;
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || fire) begin
      if (skid_vld_q) begin
        out_d     = skid_q;
        out_vld_d = 1'b1;
        if (arrive) skid_d = arr_e;
        else        skid_vld_d = 1'b0;
      end else if (arrive) begin
        out_d     = arr_e;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (arrive) begin
      skid_d     = arr_e;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      route_q    <= '0;
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_vld_q;
  assign bus.out_data   = out_q.data;
  assign bus.out_port   = out_q.port;
  assign bus.out_head   = out_q.head;
  assign bus.out_tail   = out_q.tail;
  assign bus.err_flit   = err;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_input_route_unit.sv
// Directed bench for input_route_unit at router (1,0), with a behavioural
// one-cycle-latency FIFO feeding it.
module tb_input_route_unit;
  localparam int W  = 32;
  localparam int EW = W + 7;
  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_E = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_W = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;
  always #5 clk = ~clk;

  input_route_unit_if #(.DATA_WIDTH(W)) bus ();

  input_route_unit #(.CUR_X(1), .CUR_Y(0), .DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0]  fifo_q[$];
  logic [EW-1:0] exp_q[$];

  // FIFO model: pushes made at a negedge become visible as not-empty after the next posedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      bus.fifo_empty   <= 1'b1;
      bus.fifo_rd_data <= '0;
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_rd_data <= fifo_q.pop_front();
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, bus.fifo_rd_en, bus.err_flit, bus.out_head, bus.out_tail} !== 5'b0)
      begin n_err++; $display("FAIL reset_ctrl: got %b expected 00000",
        {bus.out_valid, bus.fifo_rd_en, bus.err_flit, bus.out_head, bus.out_tail}); end
    n_vec++;
    if ({bus.out_port, bus.out_data} !== '0)
      begin n_err++; $display("FAIL reset_data: got %h/%h expected 0", bus.out_port, bus.out_data); end
    n_vec++;
    if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b expected 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    @(negedge clk);
    fifo_q.push_back(32'hE800_0000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== (c == 3))
        begin n_err++; $display("FAIL single_valid c%0d: got %b expected %b", c, bus.out_valid, c == 3); end
      if (c == 1) begin
        n_vec++;
        if (bus.fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL single_pop: got %b expected 1", bus.fifo_rd_en); end
      end
      if (c == 3) begin
        n_vec++;
        if ({bus.out_port, bus.out_head, bus.out_tail, bus.out_data} !== {P_E, 1'b1, 1'b1, 32'hE800_0000})
          begin n_err++; $display("FAIL single_flit: got %h/%b%b/%h expected 04/11/e8000000",
            bus.out_port, bus.out_head, bus.out_tail, bus.out_data); end
      end
    end
  endtask

  task automatic test_packet();
    logic [W-1:0] d [4];
    int got = 0;
    int first = -1;
    int last = -1;
    d[0] = 32'h5800_0000; d[1] = 32'h0000_0001; d[2] = 32'h0000_0002; d[3] = 32'h8000_0003;
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(d[i]);
      exp_q.push_back({P_S, i == 0, i == 3, d[i]});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL pkt_extra: got %h expected nothing", bus.out_data); end
        else if ({bus.out_port, bus.out_head, bus.out_tail, bus.out_data} !== exp_q[0])
          begin n_err++; $display("FAIL pkt_flit%0d: got %h expected %h", got,
            {bus.out_port, bus.out_head, bus.out_tail, bus.out_data}, exp_q[0]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    n_vec++;
    if (got !== 4 || last - first !== 3)
      begin n_err++; $display("FAIL pkt_b2b: got %0d flits over %0d cycles expected 4 over 4", got, last - first + 1); end
    n_vec++;
    if (dbg_state !== 1'b0) begin n_err++; $display("FAIL pkt_idle: got %b expected 0", dbg_state); end
  endtask

  task automatic test_stall();
    int got = 0, pops = 0, xfers = 0, max_over = 0, stall_left = 0;
    logic held = 1'b0;
    logic [EW-1:0] held_v, obs;
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = (i == 0) ? 32'h4000_0000 : (i == 7) ? 32'h8000_0017 : W'(32'h10 + i);
      fifo_q.push_back(d);
      exp_q.push_back({P_W, i == 0, i == 7, d});
    end
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      obs = {bus.out_port, bus.out_head, bus.out_tail, bus.out_data};
      if (bus.fifo_rd_en) pops++;
      if (bus.out_valid && !bus.out_ready) begin
        if (held) begin
          n_vec++;
          if (obs !== held_v) begin n_err++; $display("FAIL stall_hold: got %h expected %h", obs, held_v); end
        end
        held_v = obs;
        held   = 1'b1;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_extra: got %h expected nothing", obs); end
        else if (obs !== exp_q[0]) begin n_err++; $display("FAIL stall_flit%0d: got %h expected %h", got, obs, exp_q[0]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
        xfers++;
        if (got == 3) stall_left = 5;
      end
      if (pops - xfers > max_over) max_over = pops - xfers;
    end
    n_vec++;
    if (got !== 8) begin n_err++; $display("FAIL stall_count: got %0d expected 8", got); end
    n_vec++;
    if (max_over !== 2) begin n_err++; $display("FAIL stall_popahead: got %0d expected 2", max_over); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_err_idle();
    fifo_q.push_back(32'h0000_0055);
    fifo_q.push_back(32'hD000_0000);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.err_flit !== (c == 2))
        begin n_err++; $display("FAIL idle_err c%0d: got %b expected %b", c, bus.err_flit, c == 2); end
      n_vec++;
      if (bus.out_valid !== (c == 4))
        begin n_err++; $display("FAIL idle_valid c%0d: got %b expected %b", c, bus.out_valid, c == 4); end
      if (c <= 2) begin
        n_vec++;
        if (bus.fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL idle_pop c%0d: got %b expected 1", c, bus.fifo_rd_en); end
      end
      if (c == 4) begin
        n_vec++;
        if ({bus.out_port, bus.out_head, bus.out_tail, bus.out_data} !== {P_L, 1'b1, 1'b1, 32'hD000_0000})
          begin n_err++; $display("FAIL idle_next: got %h/%b%b/%h expected 01/11/d0000000",
            bus.out_port, bus.out_head, bus.out_tail, bus.out_data); end
      end
    end
  endtask

  task automatic test_head_in_pkt();
    int got = 0;
    fifo_q.push_back(32'h6000_0000); exp_q.push_back({P_E, 1'b1, 1'b0, 32'h6000_0000});
    fifo_q.push_back(32'h0000_0021); exp_q.push_back({P_E, 1'b0, 1'b0, 32'h0000_0021});
    fifo_q.push_back(32'h4800_0000); exp_q.push_back({P_W, 1'b1, 1'b0, 32'h4800_0000});
    fifo_q.push_back(32'h0000_0022); exp_q.push_back({P_W, 1'b0, 1'b0, 32'h0000_0022});
    fifo_q.push_back(32'h8000_0023); exp_q.push_back({P_W, 1'b0, 1'b1, 32'h8000_0023});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.err_flit !== (c == 4))
        begin n_err++; $display("FAIL pkt_err c%0d: got %b expected %b", c, bus.err_flit, c == 4); end
      if (bus.out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rehead_extra: got %h expected nothing", bus.out_data); end
        else if ({bus.out_port, bus.out_head, bus.out_tail, bus.out_data} !== exp_q[0])
          begin n_err++; $display("FAIL rehead_flit%0d: got %h expected %h", got,
            {bus.out_port, bus.out_head, bus.out_tail, bus.out_data}, exp_q[0]); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
    end
    n_vec++;
    if (got !== 5) begin n_err++; $display("FAIL rehead_count: got %0d expected 5", got); end
    n_vec++;
    if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rehead_idle: got %b expected 0", dbg_state); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    fifo_q.push_back(32'h5800_0000);
    fifo_q.push_back(32'h0000_0001);
    fifo_q.push_back(32'h0000_0002);
    fifo_q.push_back(32'h8000_0003);
    repeat (4) @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, bus.fifo_rd_en} !== 2'b10)
      begin n_err++; $display("FAIL rst_full: got %b expected 10", {bus.out_valid, bus.fifo_rd_en}); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.fifo_rd_en, bus.err_flit, bus.out_head, bus.out_tail, bus.out_port, bus.out_data, dbg_state} !== '0)
      begin n_err++; $display("FAIL rst_clear: got %b/%h/%h expected all 0",
        {bus.out_valid, bus.fifo_rd_en, bus.err_flit, bus.out_head, bus.out_tail, dbg_state}, bus.out_port, bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    fifo_q.push_back(32'hC800_0000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== (c == 3))
        begin n_err++; $display("FAIL rst_valid c%0d: got %b expected %b", c, bus.out_valid, c == 3); end
      if (c == 3) begin
        n_vec++;
        if ({bus.out_port, bus.out_head, bus.out_tail, bus.out_data} !== {P_W, 1'b1, 1'b1, 32'hC800_0000})
          begin n_err++; $display("FAIL rst_fresh: got %h/%b%b/%h expected 10/11/c8000000",
            bus.out_port, bus.out_head, bus.out_tail, bus.out_data); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_single();
    repeat (2) @(negedge clk);
    test_packet();
    repeat (2) @(negedge clk);
    test_stall();
    repeat (2) @(negedge clk);
    test_err_idle();
    repeat (2) @(negedge clk);
    test_head_in_pkt();
    repeat (2) @(negedge clk);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
